// File: rtl/nn_pkg.sv
// Shared constants and the reader FSM state encoding used by the weight,
// activation and layer-2 readers.
package nn_pkg;

  localparam int NN_DATA_W = 32;
  localparam int NN_ADDR_W = 16;
  localparam int L1_ROWS   = 64;
  localparam int L1_COLS   = 784;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    FLUSH = ST_FLUSH,
    DONE  = ST_DONE
  } state_e;

endpackage

// File: rtl/weight_stream_reader_if.sv
// ROM address/data bus plus the tagged weight stream towards the MAC array.
// Stream handshake: a word moves on every rising edge where out_valid and
// out_ready are both 1; while out_valid is high and out_ready low the
// initiator holds every out_* field stable, and out_valid never depends on out_ready.
interface weight_stream_reader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int ROW_W  = 6,
  parameter int COL_W  = 10
);

  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] out_data;
  logic [ROW_W-1:0]  out_row;
  logic [COL_W-1:0]  out_col;
  logic              out_row_last;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output rom_addr,
    input  rom_data,
    output out_data, out_row, out_col, out_row_last, out_last, out_valid,
    input  out_ready
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  out_data, out_row, out_col, out_row_last, out_last, out_valid,
    output out_ready
  );

endinterface

// File: rtl/weight_idx_counter.sv
// Row-major index walker: row/col/address advance together on en, saturating
// at the final element so the address never leaves the matrix.
module weight_idx_counter
  import nn_pkg::*;
#(
  parameter int N_ROWS = L1_ROWS,
  parameter int N_COLS = L1_COLS,
  parameter int ADDR_W = NN_ADDR_W,
  localparam int ROW_W = $clog2(N_ROWS),
  localparam int COL_W = $clog2(N_COLS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              en_i,
  output logic [ROW_W-1:0]  row_o,
  output logic [COL_W-1:0]  col_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              row_last_o,
  output logic              last_o
);

  localparam int DEPTH = N_ROWS * N_COLS;

  logic [ROW_W-1:0]  row_q,  row_d;
  logic [COL_W-1:0]  col_q,  col_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  assign row_last_o = (col_q == COL_W'(N_COLS - 1));
  assign last_o     = (addr_q == ADDR_W'(DEPTH - 1));

  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    addr_d = addr_q;
    if (clr_i) begin
      row_d  = '0;
      col_d  = '0;
      addr_d = '0;
    end else if (en_i && !last_o) begin
      // Address is a running count rather than row*N_COLS+col.
      addr_d = addr_q + ADDR_W'(1);
      if (row_last_o) begin
        col_d = '0;
        row_d = row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q  <= '0;
      col_q  <= '0;
      addr_q <= '0;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      addr_q <= addr_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign addr_o = addr_q;

endmodule

// File: rtl/weight_stream_reader.sv
// Walks the weight ROM in row-major order and emits each word as a tagged
// valid/ready stream; one output register stage with a start/abort FSM.
module weight_stream_reader
  import nn_pkg::*;
#(
  parameter int DATA_W = NN_DATA_W,
  parameter int ADDR_W = NN_ADDR_W,
  parameter int N_ROWS = L1_ROWS,
  parameter int N_COLS = L1_COLS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  weight_stream_reader_if.master bus,
  output logic                   busy,
  output logic                   done,
  output state_e                 dbg_state
);

  localparam int ROW_W = $clog2(N_ROWS);
  localparam int COL_W = $clog2(N_COLS);

  state_e state_q, state_d;

  logic [DATA_W-1:0] out_data_q;
  logic [ROW_W-1:0]  out_row_q;
  logic [COL_W-1:0]  out_col_q;
  logic              out_row_last_q;
  logic              out_last_q;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, done_q;

  logic              load, xfer, load_en, cnt_clr, cnt_en;
  logic [ROW_W-1:0]  cnt_row;
  logic [COL_W-1:0]  cnt_col;
  logic [ADDR_W-1:0] cnt_addr;
  logic              cnt_row_last, cnt_last;

  weight_idx_counter #(
    .N_ROWS (N_ROWS),
    .N_COLS (N_COLS),
    .ADDR_W (ADDR_W)
  ) u_idx (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (cnt_clr),
    .en_i       (cnt_en),
    .row_o      (cnt_row),
    .col_o      (cnt_col),
    .addr_o     (cnt_addr),
    .row_last_o (cnt_row_last),
    .last_o     (cnt_last)
  );

  assign load = !out_valid_q || out_ready_w();
  assign xfer = out_valid_q && bus.out_ready;

  function automatic logic out_ready_w();
    return bus.out_ready;
  endfunction

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    load_en     = 1'b0;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    if (abort) begin
      // Cancel wins over start and over a same-cycle transfer.
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = ISSUE;
            cnt_clr = 1'b1;
          end
        end
        ISSUE: begin
          if (load) begin
            load_en     = 1'b1;
            cnt_en      = 1'b1;
            out_valid_d = 1'b1;
            if (cnt_last) state_d = FLUSH;
          end
        end
        FLUSH: begin
          if (xfer) begin
            out_valid_d = 1'b0;
            state_d     = DONE;
          end else if (!out_valid_q) begin
            state_d = DONE;
          end
        end
        DONE: state_d = IDLE;
        default: begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      out_data_q     <= '0;
      out_row_q      <= '0;
      out_col_q      <= '0;
      out_row_last_q <= 1'b0;
      out_last_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_d == DONE);
      if (load_en) begin
        out_data_q     <= bus.rom_data;
        out_row_q      <= cnt_row;
        out_col_q      <= cnt_col;
        out_row_last_q <= cnt_row_last;
        out_last_q     <= cnt_last;
      end
    end
  end

  assign bus.rom_addr     = cnt_addr;
  assign bus.out_data     = out_data_q;
  assign bus.out_row      = out_row_q;
  assign bus.out_col      = out_col_q;
  assign bus.out_row_last = out_row_last_q;
  assign bus.out_last     = out_last_q;
  assign bus.out_valid    = out_valid_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_weight_stream_reader.sv
// Directed bench for weight_stream_reader: a full 64x784 reader and a 2x3
// reader share one clock; each scenario task checks its own results.
module tb_weight_stream_reader;
  import nn_pkg::*;

  logic   clk;
  logic   reset;
  logic   big_start, big_abort, small_start, small_abort;
  logic   big_busy, big_done, small_busy, small_done;
  state_e big_state, small_state;
  int     n_checks;
  int     n_errors;

  weight_stream_reader_if #(.DATA_W(32), .ADDR_W(16), .ROW_W(6), .COL_W(10)) big_if ();
  weight_stream_reader_if #(.DATA_W(32), .ADDR_W(16), .ROW_W(1), .COL_W(2))  small_if ();

  weight_stream_reader u_big (
    .clk       (clk),
    .reset     (reset),
    .start     (big_start),
    .abort     (big_abort),
    .bus       (big_if.master),
    .busy      (big_busy),
    .done      (big_done),
    .dbg_state (big_state)
  );

  weight_stream_reader #(.DATA_W(32), .ADDR_W(16), .N_ROWS(2), .N_COLS(3)) u_small (
    .clk       (clk),
    .reset     (reset),
    .start     (small_start),
    .abort     (small_abort),
    .bus       (small_if.master),
    .busy      (small_busy),
    .done      (small_done),
    .dbg_state (small_state)
  );

  function automatic logic [31:0] rom_word(input logic [15:0] a);
    return {a, ~a} ^ 32'h5A3C_0F96;
  endfunction

  assign big_if.rom_data   = rom_word(big_if.rom_addr);
  assign small_if.rom_data = rom_word(small_if.rom_addr);

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    big_start = 1'b0; big_abort = 1'b0; small_start = 1'b0; small_abort = 1'b0;
    big_if.out_ready = 1'b0; small_if.out_ready = 1'b0;
    tick(); tick();
    n_checks++; if (big_if.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b exp 0", big_if.out_valid); end
    n_checks++; if (big_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b exp 0", big_busy); end
    n_checks++; if (big_done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b exp 0", big_done); end
    n_checks++; if (big_if.rom_addr !== 16'd0) begin n_errors++; $display("FAIL reset_addr: got %0d exp 0", big_if.rom_addr); end
    n_checks++; if (big_if.out_data !== 32'd0) begin n_errors++; $display("FAIL reset_data: got %h exp 0", big_if.out_data); end
    n_checks++; if (big_state !== IDLE) begin n_errors++; $display("FAIL reset_state: got %0d exp IDLE", big_state); end
    n_checks++; if (small_if.out_valid !== 1'b0 || small_busy !== 1'b0) begin n_errors++; $display("FAIL reset_small: valid %b busy %b exp 0 0", small_if.out_valid, small_busy); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_full_pass();
    int n, errs, first_bad, first_valid, done_cyc, last_cnt, addr_bad;
    n = 0; errs = 0; first_bad = -1; first_valid = -1; done_cyc = -1; last_cnt = 0; addr_bad = 0;
    big_if.out_ready = 1'b1;
    big_start = 1'b1;
    for (int cyc = 1; cyc <= 50300; cyc++) begin
      tick();
      big_start = 1'b0;
      if (big_if.rom_addr > 16'd50175) addr_bad++;
      if (big_done) begin done_cyc = cyc; break; end
      if (big_if.out_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (big_if.out_data !== rom_word(16'(n)) || big_if.out_row !== 6'(n / 784) ||
            big_if.out_col !== 10'(n % 784) || big_if.out_row_last !== ((n % 784) == 783) ||
            big_if.out_last !== (n == 50175)) begin
          errs++;
          if (first_bad < 0) first_bad = n;
        end
        if (big_if.out_last) last_cnt++;
        n++;
      end
    end
    n_checks++; if (first_valid != 2) begin n_errors++; $display("FAIL full_first_latency: got %0d exp 2", first_valid); end
    n_checks++; if (done_cyc != 50178) begin n_errors++; $display("FAIL full_done_cycle: got %0d exp 50178", done_cyc); end
    n_checks++; if (n != 50176) begin n_errors++; $display("FAIL full_word_count: got %0d exp 50176", n); end
    n_checks++; if (errs != 0) begin n_errors++; $display("FAIL full_word_content: %0d bad words (first %0d) exp 0", errs, first_bad); end
    n_checks++; if (addr_bad != 0) begin n_errors++; $display("FAIL full_addr_range: %0d cycles above 50175 exp 0", addr_bad); end
    n_checks++; if (last_cnt != 1) begin n_errors++; $display("FAIL full_last_count: got %0d exp 1", last_cnt); end
    n_checks++; if (big_if.out_valid !== 1'b0 || big_busy !== 1'b1) begin n_errors++; $display("FAIL full_done_cycle_flags: valid %b busy %b exp 0 1", big_if.out_valid, big_busy); end
    tick();
    n_checks++; if (big_done !== 1'b0 || big_busy !== 1'b0) begin n_errors++; $display("FAIL full_after_done: done %b busy %b exp 0 0", big_done, big_busy); end
  endtask

  task automatic test_row_boundary();
    int n;
    logic [5:0] r783, r784;
    logic [9:0] c783, c784;
    logic       l783, l784;
    n = 0; r783 = 'x; r784 = 'x; c783 = 'x; c784 = 'x; l783 = 'x; l784 = 'x;
    big_if.out_ready = 1'b1;
    big_start = 1'b1;
    tick();
    big_start = 1'b0;
    for (int c = 0; c < 900 && n < 785; c++) begin
      tick();
      if (big_if.out_valid) begin
        if (n == 783) begin r783 = big_if.out_row; c783 = big_if.out_col; l783 = big_if.out_row_last; end
        if (n == 784) begin r784 = big_if.out_row; c784 = big_if.out_col; l784 = big_if.out_row_last; end
        n++;
      end
    end
    big_abort = 1'b1;
    tick();
    big_abort = 1'b0;
    n_checks++; if (r783 !== 6'd0 || c783 !== 10'd783) begin n_errors++; $display("FAIL row_bnd_783_idx: got r%0d c%0d exp r0 c783", r783, c783); end
    n_checks++; if (l783 !== 1'b1) begin n_errors++; $display("FAIL row_bnd_783_last: got %b exp 1", l783); end
    n_checks++; if (r784 !== 6'd1 || c784 !== 10'd0) begin n_errors++; $display("FAIL row_bnd_784_idx: got r%0d c%0d exp r1 c0", r784, c784); end
    n_checks++; if (l784 !== 1'b0) begin n_errors++; $display("FAIL row_bnd_784_last: got %b exp 0", l784); end
  endtask

  task automatic test_abort_restart();
    int n, errs, stab, reached, saw_done;
    logic        held;
    logic [31:0] p_data;
    logic [5:0]  p_row;
    logic [9:0]  p_col;
    logic [15:0] p_addr;
    n = 0; errs = 0; stab = 0; reached = 0; saw_done = 0; held = 1'b0;
    p_data = '0; p_row = '0; p_col = '0; p_addr = '0;
    big_if.out_ready = 1'b0;
    big_start = 1'b1;
    tick();
    big_start = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      tick();
      if (held && (big_if.out_valid !== 1'b1 || big_if.out_data !== p_data || big_if.out_row !== p_row ||
                   big_if.out_col !== p_col || big_if.rom_addr !== p_addr)) stab++;
      if (big_if.out_valid) begin
        if (big_if.out_data !== rom_word(16'(n)) || big_if.out_row !== 6'(n / 784) ||
            big_if.out_col !== 10'(n % 784) || big_if.out_last !== 1'b0) errs++;
        if (n == 1000) begin reached = 1; break; end
      end
      big_if.out_ready = 1'($urandom_range(0, 1));
      held = big_if.out_valid && !big_if.out_ready;
      p_data = big_if.out_data; p_row = big_if.out_row; p_col = big_if.out_col; p_addr = big_if.rom_addr;
      if (big_if.out_valid && big_if.out_ready) n++;
    end
    big_if.out_ready = 1'b0;
    n_checks++; if (reached != 1) begin n_errors++; $display("FAIL bp_reach_1000: got %0d words exp 1000 within budget", n); end
    n_checks++; if (errs != 0) begin n_errors++; $display("FAIL bp_word_content: %0d bad words exp 0", errs); end
    n_checks++; if (stab != 0) begin n_errors++; $display("FAIL bp_stall_stable: %0d unstable stalls exp 0", stab); end
    repeat (3) tick();
    n_checks++; if (big_if.out_valid !== 1'b1 || big_if.out_data !== rom_word(16'd1000)) begin n_errors++; $display("FAIL stall_1000_data: valid %b data %h exp 1 %h", big_if.out_valid, big_if.out_data, rom_word(16'd1000)); end
    n_checks++; if (big_if.out_row !== 6'd1 || big_if.out_col !== 10'd216 || big_if.rom_addr !== 16'd1001) begin n_errors++; $display("FAIL stall_1000_idx: r%0d c%0d a%0d exp r1 c216 a1001", big_if.out_row, big_if.out_col, big_if.rom_addr); end
    big_abort = 1'b1;
    tick();
    big_abort = 1'b0;
    n_checks++; if (big_if.out_valid !== 1'b0) begin n_errors++; $display("FAIL abort_valid: got %b exp 0", big_if.out_valid); end
    n_checks++; if (big_busy !== 1'b0 || big_state !== IDLE) begin n_errors++; $display("FAIL abort_idle: busy %b state %0d exp 0 IDLE", big_busy, big_state); end
    for (int c = 0; c < 5; c++) begin
      if (big_done) saw_done = 1;
      tick();
    end
    n_checks++; if (saw_done != 0) begin n_errors++; $display("FAIL abort_no_done: got done pulse exp none"); end
    big_if.out_ready = 1'b1;
    big_start = 1'b1;
    tick();
    big_start = 1'b0;
    tick();
    n_checks++; if (big_if.out_valid !== 1'b1 || big_if.out_data !== rom_word(16'd0)) begin n_errors++; $display("FAIL restart_word0: valid %b data %h exp 1 %h", big_if.out_valid, big_if.out_data, rom_word(16'd0)); end
    n_checks++; if (big_if.out_row !== 6'd0 || big_if.out_col !== 10'd0) begin n_errors++; $display("FAIL restart_idx: r%0d c%0d exp r0 c0", big_if.out_row, big_if.out_col); end
  endtask

  task automatic test_async_reset();
    // Continues the restarted pass (word 0 presented, ready held at 1).
    repeat (300) tick();
    n_checks++; if (big_if.out_valid !== 1'b1 || big_if.out_data !== rom_word(16'd300)) begin n_errors++; $display("FAIL pre_reset_word300: valid %b data %h exp 1 %h", big_if.out_valid, big_if.out_data, rom_word(16'd300)); end
    #3;
    reset = 1'b1;
    #1;
    n_checks++; if (big_if.out_valid !== 1'b0 || big_busy !== 1'b0 || big_done !== 1'b0) begin n_errors++; $display("FAIL areset_ctrl: valid %b busy %b done %b exp 0 0 0", big_if.out_valid, big_busy, big_done); end
    n_checks++; if (big_if.out_data !== 32'd0 || big_if.rom_addr !== 16'd0) begin n_errors++; $display("FAIL areset_data_addr: data %h addr %0d exp 0 0", big_if.out_data, big_if.rom_addr); end
    n_checks++; if (big_if.out_row !== 6'd0 || big_if.out_col !== 10'd0 || big_if.out_row_last !== 1'b0 || big_if.out_last !== 1'b0) begin n_errors++; $display("FAIL areset_tags: r%0d c%0d rl%b l%b exp all 0", big_if.out_row, big_if.out_col, big_if.out_row_last, big_if.out_last); end
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_start_ignored_and_idle_abort();
    int n;
    n = 0;
    big_if.out_ready = 1'b1;
    big_start = 1'b1;
    tick();
    big_start = 1'b0;
    for (int c = 0; c < 20 && n < 5; c++) begin
      tick();
      if (big_if.out_valid) n++;
    end
    big_start = 1'b1;
    tick();
    big_start = 1'b0;
    n_checks++; if (big_if.out_data !== rom_word(16'd5) || big_if.out_col !== 10'd5) begin n_errors++; $display("FAIL start_ignored_busy: data %h col %0d exp %h 5", big_if.out_data, big_if.out_col, rom_word(16'd5)); end
    big_abort = 1'b1;
    tick();
    big_abort = 1'b0;
    big_start = 1'b1;
    big_abort = 1'b1;
    tick();
    big_start = 1'b0;
    big_abort = 1'b0;
    n_checks++; if (big_busy !== 1'b0 || big_state !== IDLE) begin n_errors++; $display("FAIL start_abort_idle: busy %b state %0d exp 0 IDLE", big_busy, big_state); end
    tick();
    n_checks++; if (big_if.out_valid !== 1'b0 || big_busy !== 1'b0) begin n_errors++; $display("FAIL start_abort_idle_next: valid %b busy %b exp 0 0", big_if.out_valid, big_busy); end
  endtask

  task automatic test_small_flush();
    int n, bad;
    n = 0; bad = 0;
    small_if.out_ready = 1'b1;
    small_start = 1'b1;
    tick();
    small_start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (small_if.out_valid) begin
        if (n == 5) break;
        n++;
      end
    end
    small_if.out_ready = 1'b0;
    n_checks++; if (n != 5) begin n_errors++; $display("FAIL small_reach_last: got %0d exp 5", n); end
    for (int c = 0; c < 5; c++) begin
      tick();
      if (small_state !== FLUSH || small_if.out_valid !== 1'b1 || small_if.out_data !== rom_word(16'd5) ||
          small_if.out_last !== 1'b1 || small_if.out_row !== 1'd1 || small_if.out_col !== 2'd2 ||
          small_if.rom_addr !== 16'd5 || small_done !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_errors++; $display("FAIL small_flush_hold: %0d bad cycles exp 0", bad); end
    small_if.out_ready = 1'b1;
    tick();
    small_if.out_ready = 1'b0;
    n_checks++; if (small_done !== 1'b1 || small_if.out_valid !== 1'b0) begin n_errors++; $display("FAIL small_done_pulse: done %b valid %b exp 1 0", small_done, small_if.out_valid); end
    tick();
    n_checks++; if (small_done !== 1'b0 || small_busy !== 1'b0) begin n_errors++; $display("FAIL small_done_end: done %b busy %b exp 0 0", small_done, small_busy); end
  endtask

  task automatic test_small_backpressure();
    int n, errs, stab, addr_bad, saw_done;
    logic        held;
    logic [31:0] p_data;
    logic [15:0] p_addr;
    n = 0; errs = 0; stab = 0; addr_bad = 0; saw_done = 0; held = 1'b0; p_data = '0; p_addr = '0;
    small_if.out_ready = 1'b0;
    small_start = 1'b1;
    tick();
    small_start = 1'b0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (small_if.rom_addr > 16'd5) addr_bad++;
      if (held && (small_if.out_valid !== 1'b1 || small_if.out_data !== p_data || small_if.rom_addr !== p_addr)) stab++;
      if (small_done) begin saw_done = 1; break; end
      if (small_if.out_valid) begin
        if (small_if.out_data !== rom_word(16'(n)) || small_if.out_row !== 1'(n / 3) || small_if.out_col !== 2'(n % 3) ||
            small_if.out_row_last !== ((n % 3) == 2) || small_if.out_last !== (n == 5)) errs++;
      end
      small_if.out_ready = 1'($urandom_range(0, 1));
      held = small_if.out_valid && !small_if.out_ready;
      p_data = small_if.out_data; p_addr = small_if.rom_addr;
      if (small_if.out_valid && small_if.out_ready) n++;
    end
    small_if.out_ready = 1'b0;
    n_checks++; if (n != 6) begin n_errors++; $display("FAIL small_bp_count: got %0d exp 6", n); end
    n_checks++; if (errs != 0) begin n_errors++; $display("FAIL small_bp_content: %0d bad samples exp 0", errs); end
    n_checks++; if (stab != 0) begin n_errors++; $display("FAIL small_bp_stable: %0d unstable stalls exp 0", stab); end
    n_checks++; if (addr_bad != 0) begin n_errors++; $display("FAIL small_bp_addr: %0d cycles above 5 exp 0", addr_bad); end
    n_checks++; if (saw_done != 1) begin n_errors++; $display("FAIL small_bp_done: got %0d exp 1", saw_done); end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_full_pass();
    test_row_boundary();
    test_abort_restart();
    test_async_reset();
    test_start_ignored_and_idle_abort();
    test_small_flush();
    test_small_backpressure();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
